serial_deser_rx: RTL and testbench

Serial-to-parallel receiver that terminates the MSB-first serial stream produced by the team's 4-bit parallel-load/shift register transmitter. The transmitter's SO drives `sin`, and its shift strobe drives `sin_en`. The block collects WIDTH bits into a word and presents it on a valid/ready parallel output with a one-word holding buffer. It flags overruns and supports frame resynchronisation.

---
 rtl/serial_deser_rx.sv | 117 +++++++++++
 tb/tb_serial_deser_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_deser_rx.sv
// MSB-first serial-to-parallel receiver with a one-word valid/ready output buffer.
// Latency: word valid one cycle after its last bit edge; downstream stall drops the next completed word and sets sticky overrun.
module serial_deser_rx #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             frame_sync,
    input  logic             clr,
    input  logic             dout_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             overrun,
    output logic             busy,
    output logic [CW-1:0]    bit_cnt
);

    typedef enum logic {IDLE, RECV} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             vld_q, vld_d;
    logic             ovr_q, ovr_d;

    logic             restart;
    logic             last_bit;
    logic             complete;
    logic             buf_free;
    logic [WIDTH-1:0] word;

    assign restart  = frame_sync | clr;
    assign word     = {sreg_q[WIDTH-2:0], sin};
    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    assign buf_free = !vld_q || dout_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        complete = 1'b0;
        // A strobe coinciding with a restart becomes bit 0 of the new word.
        if (restart) begin
            if (sin_en) begin
                cnt_d   = CW'(1);
                state_d = RECV;
            end else begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        end else if (sin_en) begin
            case (state_q)
                IDLE: begin
                    cnt_d   = CW'(1);
                    state_d = RECV;
                end
                RECV: begin
                    if (last_bit) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sreg_d = sin_en ? word : sreg_q;
        dout_d = dout_q;
        vld_d  = vld_q;
        ovr_d  = ovr_q;
        if (complete && buf_free) begin
            dout_d = word;
            vld_d  = 1'b1;
        end else if (vld_q && dout_ready) begin
            vld_d = 1'b0;
        end
        // clr takes priority over an overrun on the same edge.
        if (clr) begin
            ovr_d = 1'b0;
        end else if (complete && !buf_free) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = vld_q;
    assign overrun    = ovr_q;
    assign busy       = (cnt_q != '0);
    assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_serial_deser_rx.sv
// Bench for serial_deser_rx: constant vector table, directed corner sequences and random traffic vs a bit-queue model.
module tb_serial_deser_rx;
    localparam int W  = 4;
    localparam int CW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sin = 1'b0;
    logic          sin_en = 1'b0;
    logic          frame_sync = 1'b0;
    logic          clr = 1'b0;
    logic          dout_ready = 1'b0;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          overrun;
    logic          busy;
    logic [CW-1:0] bit_cnt;

    int nvec = 0;
    int nerr = 0;

    serial_deser_rx #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en),
        .frame_sync(frame_sync), .clr(clr), .dout_ready(dout_ready),
        .dout(dout), .dout_valid(dout_valid), .overrun(overrun),
        .busy(busy), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    // Reference: bits of the current partial word kept as a plain queue.
    logic         m_bits[$];
    logic [W-1:0] m_dout;
    logic         m_vld;
    logic         m_ovr;

    task automatic model_reset();
        m_bits.delete();
        m_dout = '0;
        m_vld  = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic model_edge(input logic en, s, fs, cl, rdy);
        logic         done = 1'b0;
        logic         free;
        logic [W-1:0] w = '0;
        if (fs || cl) m_bits.delete();
        if (en) begin
            m_bits.push_back(s);
            if (m_bits.size() == W) begin
                for (int i = 0; i < W; i++) w[W-1-i] = m_bits[i];
                m_bits.delete();
                done = 1'b1;
            end
        end
        free = !m_vld || rdy;
        if (done && free) begin
            m_dout = w;
            m_vld  = 1'b1;
        end else if (m_vld && rdy) begin
            m_vld = 1'b0;
        end
        if (cl) m_ovr = 1'b0;
        else if (done && !free) m_ovr = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        chk("dout", 32'(dout), 32'(m_dout));
        chk("dout_valid", 32'(dout_valid), 32'(m_vld));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("bit_cnt", 32'(bit_cnt), m_bits.size());
        chk("busy", 32'(busy), 32'(m_bits.size() != 0));
    endtask

    task automatic step(input logic en, s, fs, cl, rdy);
        sin_en = en; sin = s; frame_sync = fs; clr = cl; dout_ready = rdy;
        @(posedge clk);
        model_edge(en, s, fs, cl, rdy);
        #1;
        check_model();
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic rdy);
        for (int i = W - 1; i >= 0; i--) step(1'b1, w[i], 1'b0, 1'b0, rdy);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_dout"}, 32'(dout), 0);
        chk({tag, "_valid"}, 32'(dout_valid), 0);
        chk({tag, "_overrun"}, 32'(overrun), 0);
        chk({tag, "_bit_cnt"}, 32'(bit_cnt), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    typedef struct {
        logic         en, s, fs, cl, rdy;
        logic [W-1:0] e_dout;
        logic         e_vld, e_ovr;
        int           e_cnt;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [W-1:0] tx;
        bit           seen;

        // single word, ready high
        tbl.push_back('{1, 1, 0, 0, 1, 4'h0, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 0, 1, 4'h0, 0, 0, 2});
        tbl.push_back('{1, 1, 0, 0, 1, 4'h0, 0, 0, 3});
        tbl.push_back('{1, 1, 0, 0, 1, 4'hB, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 4'hB, 0, 0, 0});
        // back-to-back: transfer and completion on the same edge
        tbl.push_back('{1, 1, 0, 0, 1, 4'hB, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 0, 1, 4'hB, 0, 0, 2});
        tbl.push_back('{1, 1, 0, 0, 1, 4'hB, 0, 0, 3});
        tbl.push_back('{1, 1, 0, 0, 1, 4'hB, 1, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 4'hB, 1, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 0, 4'hB, 1, 0, 2});
        tbl.push_back('{1, 1, 0, 0, 0, 4'hB, 1, 0, 3});
        tbl.push_back('{1, 0, 0, 0, 1, 4'h6, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 4'h6, 0, 0, 0});
        // overrun with ready low, then drain, then clr
        tbl.push_back('{1, 1, 0, 0, 0, 4'h6, 0, 0, 1});
        tbl.push_back('{1, 0, 0, 0, 0, 4'h6, 0, 0, 2});
        tbl.push_back('{1, 1, 0, 0, 0, 4'h6, 0, 0, 3});
        tbl.push_back('{1, 1, 0, 0, 0, 4'hB, 1, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 4'hB, 1, 0, 1});
        tbl.push_back('{1, 1, 0, 0, 0, 4'hB, 1, 0, 2});
        tbl.push_back('{1, 1, 0, 0, 0, 4'hB, 1, 0, 3});
        tbl.push_back('{1, 0, 0, 0, 0, 4'hB, 1, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 4'hB, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 1, 0, 4'hB, 0, 0, 0});

        model_reset();
        #12;
        check_zero("reset");
        rst = 1'b0;
        #9;

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].s, tbl[i].fs, tbl[i].cl, tbl[i].rdy);
            chk($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].e_dout));
            chk($sformatf("tbl%0d_valid", i), 32'(dout_valid), 32'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_overrun", i), 32'(overrun), 32'(tbl[i].e_ovr));
            chk($sformatf("tbl%0d_bit_cnt", i), 32'(bit_cnt), 32'(tbl[i].e_cnt));
        end

        // gapped strobe 0,1,1,0 with three idle cycles between bits
        tx = 4'b0110;
        for (int i = W - 1; i >= 0; i--) begin
            step(1'b1, tx[i], 1'b0, 1'b0, 1'b1);
            if (i != 0) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                    chk("gap_busy", 32'(busy), 1);
                end
            end
        end
        chk("gap_dout", 32'(dout), 32'h6);
        chk("gap_valid", 32'(dout_valid), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // resync: 1,1 discarded, restart bit 1 then 0,0,1
        seen = 1'b0;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("sync_bit_cnt", 32'(bit_cnt), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        seen = seen | dout_valid;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        seen = seen | dout_valid;
        chk("sync_no_early_word", 32'(seen), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("sync_dout", 32'(dout), 32'h9);
        chk("sync_valid", 32'(dout_valid), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // clr colliding with an overrun: clr wins, bit restarts the word
        send_word(4'hC, 1'b0);
        for (int i = 0; i < W - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("clr_col_overrun", 32'(overrun), 0);
        chk("clr_col_bit_cnt", 32'(bit_cnt), 1);
        chk("clr_col_dout", 32'(dout), 32'hC);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // loopback from a parallel-load shift transmitter, held unconsumed
        tx = 4'hA;
        for (int i = 0; i < W; i++) begin
            step(1'b1, tx[W-1], 1'b0, 1'b0, 1'b0);
            tx = {tx[W-2:0], 1'b0};
        end
        chk("loop_dout", 32'(dout), 32'hA);
        chk("loop_valid", 32'(dout_valid), 1);

        // reset mid-frame
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 check_zero("midrst");
        model_reset();
        #2 rst = 1'b0;
        send_word(4'h5, 1'b0);
        chk("postrst_dout", 32'(dout), 32'h5);
        chk("postrst_valid", 32'(dout_valid), 1);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) != 0, 1'($urandom), ($urandom % 37) == 0,
                 ($urandom % 53) == 0, ($urandom % 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
